// File: rtl/spi_cmd_slave_if.sv
// Bundles the SPI pad signals and the command/response side of spi_cmd_slave.
interface spi_cmd_slave_if #(
    parameter int unsigned LEN_SPI      = 32,
    parameter int unsigned SPI_CODE_LEN = 6,
    parameter int unsigned SPI_ADDR_LEN = 10,
    parameter int unsigned SPI_DATA_LEN = 16
);
    logic                    sck;
    logic                    mosi;
    logic                    cs_n;
    logic                    miso;
    logic [LEN_SPI-1:0]      rsp_data;
    logic                    rsp_valid;
    logic [SPI_CODE_LEN-1:0] cmd_code;
    logic [SPI_ADDR_LEN-1:0] cmd_addr;
    logic [SPI_DATA_LEN-1:0] cmd_data;
    logic                    cmd_valid;
    logic                    frame_err;

    modport slave (
        input  sck, mosi, cs_n, rsp_data, rsp_valid,
        output miso, cmd_code, cmd_addr, cmd_data, cmd_valid, frame_err
    );

    modport master (
        output sck, mosi, cs_n, rsp_data, rsp_valid,
        input  miso, cmd_code, cmd_addr, cmd_data, cmd_valid, frame_err
    );
endinterface

// File: rtl/spi_cmd_slave.sv
// SPI command responder: oversamples sck/mosi/cs_n in the clk_50M domain, decodes
// 32-bit LSB-first frames into code/addr/data and shifts a response word out on miso.
module spi_cmd_slave #(
    parameter int unsigned LEN_SPI      = 32,
    parameter int unsigned SPI_CODE_LEN = 6,
    parameter int unsigned SPI_ADDR_LEN = 10,
    parameter int unsigned SPI_DATA_LEN = 16
) (
    input  logic            clk_50M,
    input  logic            rst_n,
    spi_cmd_slave_if.slave  spi_if
);
    localparam int unsigned CntW = 6;
    localparam int unsigned IdxW = $clog2(LEN_SPI);
    localparam logic [CntW-1:0] CntFull = CntW'(LEN_SPI);
    localparam logic [CntW-1:0] CntOvf  = CntW'(LEN_SPI + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e state_q, state_d;

    // [0] metastability flop, [1] synchronized value, [2] delayed copy for edge detection
    logic [2:0] sck_q, cs_q;
    logic [1:0] mosi_q;

    logic [LEN_SPI-1:0]      rx_q, tx_q, rsp_hold_q;
    logic [CntW-1:0]         bit_cnt_q;
    logic                    seen_fall_q;
    logic                    miso_q, cmd_valid_q, frame_err_q;
    logic [SPI_CODE_LEN-1:0] cmd_code_q;
    logic [SPI_ADDR_LEN-1:0] cmd_addr_q;
    logic [SPI_DATA_LEN-1:0] cmd_data_q;

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic frame_start, cmd_valid_d, frame_err_d;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign mosi_s   = mosi_q[1];

    // Synchronizers; cs_n clears to 0 so a select already low at reset release is no edge
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], spi_if.sck};
            cs_q   <= {cs_q[1:0], spi_if.cs_n};
            mosi_q <= {mosi_q[0], spi_if.mosi};
        end
    end

    // Frame state register
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and end-of-frame verdict
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d     = StShift;
                    frame_start = 1'b1;
                end
            end
            StShift: begin
                if (cs_rise) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (bit_cnt_q == CntFull) begin
                    cmd_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Receive/transmit shifters and bit counter (saturates at LEN_SPI+1 to flag overflow)
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_q        <= '0;
            tx_q        <= '0;
            bit_cnt_q   <= '0;
            seen_fall_q <= 1'b0;
        end else if (frame_start) begin
            tx_q        <= rsp_hold_q;
            bit_cnt_q   <= '0;
            seen_fall_q <= 1'b0;
        end else if (state_q == StShift) begin
            if (sck_fall) begin
                if (bit_cnt_q < CntFull) begin
                    rx_q[bit_cnt_q[IdxW-1:0]] <= mosi_s;
                end
                if (bit_cnt_q != CntOvf) begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                seen_fall_q <= 1'b1;
            end
            // The rise before the first fall would otherwise discard bit 0
            if (sck_rise && seen_fall_q) begin
                tx_q <= tx_q >> 1;
            end
        end
    end

    // Response holding register; a strobe in the load cycle is kept for the next frame
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rsp_hold_q <= '0;
        end else if (spi_if.rsp_valid) begin
            rsp_hold_q <= spi_if.rsp_data;
        end else if (frame_start) begin
            rsp_hold_q <= '0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            miso_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
        end else begin
            miso_q      <= (state_q == StShift) ? tx_q[0] : 1'b0;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            if (cmd_valid_d) begin
                cmd_code_q <= rx_q[LEN_SPI-1 -: SPI_CODE_LEN];
                cmd_addr_q <= rx_q[SPI_DATA_LEN +: SPI_ADDR_LEN];
                cmd_data_q <= rx_q[SPI_DATA_LEN-1:0];
            end
        end
    end

    assign spi_if.miso      = miso_q;
    assign spi_if.cmd_valid = cmd_valid_q;
    assign spi_if.frame_err = frame_err_q;
    assign spi_if.cmd_code  = cmd_code_q;
    assign spi_if.cmd_addr  = cmd_addr_q;
    assign spi_if.cmd_data  = cmd_data_q;

endmodule
